// File: rtl/scalar_muladd_mod.sv
// scalar_muladd_mod: constant-time (a*b + c) mod MODULUS engine; define SCALAR_MULADD_CANON_CHECK_EN to add the noncanon flag
module scalar_muladd_mod #(
  parameter int MOD_WIDTH = 253,
  parameter int IN_WIDTH = 256,
  parameter logic [MOD_WIDTH-1:0] MODULUS = 253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [IN_WIDTH-1:0]  a_in,
  input  logic [IN_WIDTH-1:0]  b_in,
  input  logic [IN_WIDTH-1:0]  c_in,
  output logic [MOD_WIDTH-1:0] result,
  output logic                 done,
  output logic                 busy
`ifdef SCALAR_MULADD_CANON_CHECK_EN
  ,
  output logic                 noncanon
`endif
);
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [MOD_WIDTH:0] M = {1'b0, MODULUS};
  localparam logic [IN_WIDTH-1:0] M_IN = IN_WIDTH'(MODULUS);
  typedef enum logic [1:0] {IDLE, RED, MUL, FIN} state_t;
  state_t state, state_nx;
  logic [IN_WIDTH-1:0] a_sh, b_sh, c_sh;
  logic [1:0] op;
  logic [CW-1:0] cnt;
  logic [MOD_WIDTH:0] a_red, c_red, acc;
  logic [MOD_WIDTH:0] a_dbl, c_dbl, a_nx, c_nx, acc_dbl, acc_sub, acc_add, acc_nx, fin_t, fin_r;
  logic last;
  assign last = cnt == CW'(IN_WIDTH - 1);
  assign busy = state != IDLE;
  assign a_dbl = {a_red[MOD_WIDTH-1:0], a_sh[IN_WIDTH-1]};
  assign c_dbl = {c_red[MOD_WIDTH-1:0], c_sh[IN_WIDTH-1]};
  assign a_nx = a_dbl >= M ? a_dbl - M : a_dbl;
  assign c_nx = c_dbl >= M ? c_dbl - M : c_dbl;
  assign acc_dbl = {acc[MOD_WIDTH-1:0], 1'b0};
  assign acc_sub = acc_dbl >= M ? acc_dbl - M : acc_dbl;
  assign acc_add = acc_sub + a_red;
  assign acc_nx = b_sh[IN_WIDTH-1] ? (acc_add >= M ? acc_add - M : acc_add) : acc_sub;
  assign fin_t = (op[1] ? a_red : acc) + c_red;
  assign fin_r = fin_t >= M ? fin_t - M : fin_t;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state: reduce, then multiply (modes 00/01), then a single finalise cycle
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = start ? RED : IDLE;
      RED: state_nx = last ? (op[1] ? FIN : MUL) : RED;
      MUL: state_nx = last ? FIN : MUL;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: operand latch, parallel a/c reduction, MSB-first multiply, final add
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_sh <= '0;
      b_sh <= '0;
      c_sh <= '0;
      op <= '0;
      cnt <= '0;
      a_red <= '0;
      c_red <= '0;
      acc <= '0;
      result <= '0;
      done <= 1'b0;
`ifdef SCALAR_MULADD_CANON_CHECK_EN
      noncanon <= 1'b0;
`endif
    end else begin
      done <= state == FIN;
      case (state)
        IDLE:
          if (start) begin
            a_sh <= a_in;
            b_sh <= b_in;
            c_sh <= mode[0] ? '0 : c_in;
            op <= mode;
            cnt <= '0;
            a_red <= '0;
            c_red <= '0;
            acc <= '0;
`ifdef SCALAR_MULADD_CANON_CHECK_EN
            noncanon <= (a_in >= M_IN) | (c_in >= M_IN);
`endif
          end
        RED: begin
          a_sh <= a_sh << 1;
          c_sh <= c_sh << 1;
          a_red <= a_nx;
          c_red <= c_nx;
          cnt <= last ? '0 : cnt + CW'(1);
        end
        MUL: begin
          b_sh <= b_sh << 1;
          acc <= acc_nx;
          cnt <= cnt + CW'(1);
        end
        default: result <= fin_r[MOD_WIDTH-1:0];
      endcase
    end
`ifndef SCALAR_MULADD_CANON_CHECK_EN
  logic unused;
  assign unused = ^M_IN;
`endif
endmodule

// File: tb/tb_scalar_muladd_mod.sv
// tb_scalar_muladd_mod: scoreboard bench for the default (Ed25519 L) and a small MODULUS=13 instance
module tb_scalar_muladd_mod;
  localparam logic [255:0] L = 256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;
  logic clk = 0, rst = 0, st = 0, sel = 0;
  logic [1:0] md = 0;
  logic [255:0] a = 0, b = 0, c = 0;
  logic [252:0] res;
  logic done, busy;
  logic [3:0] res8;
  logic done8, busy8;
`ifdef SCALAR_MULADD_CANON_CHECK_EN
  logic nc, nc8;
`endif
  int cyc = 0, acc_cyc = 0, n_vec = 0, n_bad = 0;
  logic [255:0] q[$], q8[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  scalar_muladd_mod dut (
    .clk(clk), .rst(rst), .start(st & ~sel), .mode(md), .a_in(a), .b_in(b), .c_in(c),
    .result(res), .done(done), .busy(busy)
`ifdef SCALAR_MULADD_CANON_CHECK_EN
    , .noncanon(nc)
`endif
  );
  scalar_muladd_mod #(.MOD_WIDTH(4), .IN_WIDTH(8), .MODULUS(4'd13)) dut8 (
    .clk(clk), .rst(rst), .start(st & sel), .mode(md), .a_in(a[7:0]), .b_in(b[7:0]), .c_in(c[7:0]),
    .result(res8), .done(done8), .busy(busy8)
`ifdef SCALAR_MULADD_CANON_CHECK_EN
    , .noncanon(nc8)
`endif
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] model(input logic [1:0] m, input logic [255:0] x, y, z, mm);
    logic [511:0] xw, yw, zw, mw, t;
    xw = x; yw = y; zw = z; mw = mm;
    t = m == 2'd0 ? (xw % mw) * (yw % mw) + zw : m == 2'd1 ? (xw % mw) * (yw % mw) : m == 2'd2 ? xw + zw : xw;
    return 256'(t % mw);
  endfunction
  // scoreboard: every done pops the oldest expected result of its instance
  always @(negedge clk) begin
    if (done) begin
      if (q.size() != 0) check("result", {3'b0, res}, q.pop_front());
      else check("spurious done", 256'(done), 0);
    end
    if (done8) begin
      if (q8.size() != 0) check("result8", 256'(res8), q8.pop_front());
      else check("spurious done8", 256'(done8), 0);
    end
  end
  task automatic launch(input logic s, input logic [1:0] m, input logic [255:0] x, y, z, exp);
    sel = s; md = m; a = x; b = y; c = z; st = 1;
    if (s) q8.push_back(exp);
    else q.push_back(exp);
    @(posedge clk);
    #1 st = 0;
    acc_cyc = cyc;
`ifdef SCALAR_MULADD_CANON_CHECK_EN
    if (!s) check("noncanon", 256'(nc), 256'((x >= L) || (z >= L)));
`endif
  endtask
  task automatic wait_done(input int lat, input int exp_busy, input string tag);
    int bc = 0, g = 0;
    forever begin
      @(negedge clk);
      if (sel ? done8 : done) break;
      bc += int'(sel ? busy8 : busy);
      if (++g > 3000) begin
        check({tag, " timeout"}, 0, 1);
        return;
      end
    end
    check({tag, " latency"}, 256'(cyc - acc_cyc), 256'(lat));
    check({tag, " busy at done"}, 256'(sel ? busy8 : busy), 0);
    if (exp_busy >= 0) check({tag, " busy cycles"}, 256'(bc), 256'(exp_busy));
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    logic [255:0] x, y, z;
    logic [1:0] m;
    int nd;
    repeat (2) @(negedge clk);
    check("reset result", {3'b0, res}, 0);
    check("reset done", 256'(done), 0);
    check("reset busy", 256'(busy), 0);
    check("reset result8", 256'(res8), 0);
    rst = 1;
    @(negedge clk);
    launch(0, 2'd0, 2, 3, L - 1, 5);
    wait_done(513, 513, "muladd");
    @(negedge clk);
    check("done pulse width", 256'(done), 0);
    launch(0, 2'd1, L - 1, L - 1, 0, 1);
    wait_done(513, -1, "mul");
    launch(0, 2'd2, L - 1, 77, 1, 0);
    wait_done(257, 257, "add");
    launch(0, 2'd3, L + 7, 99, 123, 7);
    wait_done(257, -1, "reduce");
    launch(0, 2'd2, L, 0, 5, 5);
    wait_done(257, -1, "add a=L");
    launch(0, 2'd0, '1, '1, '1, model(2'd0, '1, '1, '1, L));
    wait_done(513, -1, "all ones");
    x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    launch(0, 2'd0, x, 0, '1, model(2'd0, x, 0, '1, L));
    wait_done(513, -1, "b=0");
    launch(0, 2'd0, L - 1, L - 1, L - 1, model(2'd0, L - 1, L - 1, L - 1, L));
    repeat (256) @(negedge clk);
    #2 rst = 0;
    #1;
    check("abort result", {3'b0, res}, 0);
    check("abort done", 256'(done), 0);
    check("abort busy", 256'(busy), 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    nd = 0;
    repeat (600) begin
      @(negedge clk);
      nd += int'(done);
    end
    check("no done after abort", 256'(nd), 0);
    launch(0, 2'd0, L, 5, L, 0);
    wait_done(513, -1, "after abort");
    launch(1, 2'd0, 200, 100, 50, 4);
    wait_done(17, 17, "small muladd");
    launch(1, 2'd0, 200, 0, 255, 8);
    wait_done(17, -1, "small b=0");
    for (int i = 0; i < 20; i++) begin
      m = 2'($urandom_range(3));
      x = 256'($urandom_range(255));
      y = 256'($urandom_range(255));
      z = 256'($urandom_range(255));
      launch(1, m, x, y, z, model(m, x, y, z, 13));
      wait_done(m[1] ? 9 : 17, -1, "small random");
    end
    launch(1, 2'd0, 200, 100, 50, 4);
    repeat (8) begin
      @(negedge clk);
      st = 1;
      a = 256'($urandom);
      b = 256'($urandom);
      c = 256'($urandom);
    end
    @(negedge clk);
    st = 0;
    wait_done(17, -1, "ignored starts");
    launch(1, 2'd0, 9, 10, 11, model(2'd0, 9, 10, 11, 13));
    wait_done(17, 17, "start at done");
    repeat (4) @(negedge clk);
    check("pending results", 256'(q.size() + q8.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
